// File: rtl/xz_pkg.sv
// Shared types for the X/Z scrub monitor.
//   res_mode_e   : how flagged (x/z) bits are replaced in the scrubbed sample
//   chan_state_e : per-channel health state; 2'b11 is never entered on purpose
//   ch_width()   : channel-index width, never narrower than one bit
package xz_pkg;

  typedef enum logic [1:0] {
    RES_ZERO = 2'd0,
    RES_ONE  = 2'd1,
    RES_HOLD = 2'd2
  } res_mode_e;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'b00,
    ST_DIRTY = 2'b01,
    ST_ALARM = 2'b10,
    ST_RSVD  = 2'b11
  } chan_state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xz_scrub_monitor_if.sv
// Sample bus of the X/Z scrub monitor.
//   in_valid/in_ch/in_data           : raw 4-state sample offered to the monitor
//   out_valid/out_ch/out_data/out_xz_mask : scrubbed sample, one cycle later
// master = sample producer/consumer side, slave = the monitor.
interface xz_scrub_monitor_if
  import xz_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W = ch_width(CHANNELS);

  logic             in_valid;
  logic [CH_W-1:0]  in_ch;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_xz_mask;

  modport master (
    output in_valid, in_ch, in_data,
    input  out_valid, out_ch, out_data, out_xz_mask
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output out_valid, out_ch, out_data, out_xz_mask
  );

endinterface

// File: rtl/xz_chan_tracker.sv
// Per-channel X/Z event counter and health FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of count and state
//   ev         : one X/Z event for this channel this cycle
//   count      : saturating event count (registered)
//   state      : CLEAN/DIRTY/ALARM encoding (registered)
//   alarm_next : state of the next cycle is ALARM, lets the parent register
//                its alarm output in step with state
module xz_chan_tracker
  import xz_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int ALARM_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ev,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             alarm_next
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TH       = CNT_W'(ALARM_TH);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] base_count_s;
  logic [CNT_W-1:0] inc_count_s;
  logic [CNT_W-1:0] next_count_s;
  chan_state_e      state_r;
  chan_state_e      base_state_s;
  chan_state_e      next_state_s;

  // Next count/state: a clear is applied first, then this cycle's event on top of it.
  always_comb begin
    base_count_s = CNT_ZERO;
    base_state_s = ST_CLEAN;
    if (clr) begin
      base_count_s = CNT_ZERO;
      base_state_s = ST_CLEAN;
    end else begin
      base_count_s = count_r;
      case (state_r)
        ST_CLEAN, ST_DIRTY, ST_ALARM: base_state_s = state_r;
        default:                      base_state_s = ST_CLEAN;
      endcase
    end

    // Saturate instead of wrapping so a burst can never make a channel look healthy.
    inc_count_s = (base_count_s == CNT_MAX) ? base_count_s : base_count_s + CNT_ONE;

    next_count_s = base_count_s;
    next_state_s = base_state_s;
    if (ev) begin
      next_count_s = inc_count_s;
      case (base_state_s)
        ST_CLEAN, ST_DIRTY: next_state_s = (inc_count_s >= TH) ? ST_ALARM : ST_DIRTY;
        ST_ALARM:           next_state_s = ST_ALARM;
        default:            next_state_s = ST_CLEAN;
      endcase
    end else begin
      next_count_s = base_count_s;
      next_state_s = base_state_s;
    end

    alarm_next = (next_state_s == ST_ALARM);
  end

  // Count and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
      state_r <= ST_CLEAN;
    end else begin
      count_r <= next_count_s;
      state_r <= next_state_s;
    end
  end

  assign count = count_r;
  assign state = state_r;

endmodule

// File: rtl/xz_scrub_monitor.sv
// X/Z scrub monitor: detects x/z bits in incoming 4-state samples, replaces
// them according to MODE and tracks per-channel event counts and health.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sample bus (slave side), one-cycle latency in to out
//   clr        : clears counts and channel states, keeps last-good values
//   xz_count   : per-channel saturating event counts
//   ch_state   : per-channel CLEAN(00)/DIRTY(01)/ALARM(10)
//   alarm      : any channel in ALARM
//   err        : one-cycle pulse after a sample addressed to a missing channel
module xz_scrub_monitor
  import xz_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        CHANNELS = 4,
  parameter int        CNT_W    = 8,
  parameter int        ALARM_TH = 4,
  parameter res_mode_e MODE     = RES_ZERO
) (
  input  logic                           clk,
  input  logic                           rst_n,
  xz_scrub_monitor_if.slave              bus,
  input  logic                           clr,
  output logic [CHANNELS-1:0][CNT_W-1:0] xz_count,
  output logic [CHANNELS-1:0][1:0]       ch_state,
  output logic                           alarm,
  output logic                           err
);

  localparam int             CH_W     = ch_width(CHANNELS);
  localparam logic [CH_W:0]  CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic                           in_range_s;
  logic                           accept_s;
  logic [CH_W-1:0]                idx_s;
  logic [WIDTH-1:0]               mask_s;
  logic [WIDTH-1:0]               known_s;
  logic [WIDTH-1:0]               hold_s;
  logic [WIDTH-1:0]               res_s;
  logic [CHANNELS-1:0]            ev_s;
  logic [CHANNELS-1:0]            alarm_next_s;
  logic [CHANNELS-1:0][WIDTH-1:0] last_good_r;
  logic                           out_valid_r;
  logic [CH_W-1:0]                out_ch_r;
  logic [WIDTH-1:0]               out_data_r;
  logic [WIDTH-1:0]               out_mask_r;
  logic                           err_r;
  logic                           alarm_r;

  // Range check, per-bit x/z detection and resolve of the incoming sample.
  always_comb begin
    in_range_s = ({1'b0, bus.in_ch} < CH_LIMIT);
    accept_s   = bus.in_valid && in_range_s;
    // Out-of-range samples are dropped; the safe index only keeps the
    // last-good lookup inside the array.
    idx_s      = in_range_s ? bus.in_ch : {CH_W{1'b0}};

    // A bit that is case-unequal to both 0 and 1 must be x or z.
    mask_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = (bus.in_data[i] !== 1'b0) && (bus.in_data[i] !== 1'b1);
    end

    // ANDing with the inverted mask turns every flagged bit into a clean 0.
    known_s = bus.in_data & ~mask_s;
    hold_s  = last_good_r[idx_s];
    case (MODE)
      RES_ZERO: res_s = known_s;
      RES_ONE:  res_s = known_s | mask_s;
      RES_HOLD: res_s = known_s | (hold_s & mask_s);
      default:  res_s = known_s;
    endcase
  end

  // Event strobe for each channel tracker.
  always_comb begin
    ev_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      ev_s[c] = accept_s && (|mask_s) && (idx_s == CH_W'(c));
    end
  end

  // Output stage, error pulse, alarm and last-good registers; clr does not touch the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= {CH_W{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_mask_r  <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
      alarm_r     <= 1'b0;
      last_good_r <= {(CHANNELS*WIDTH){1'b0}};
    end else begin
      out_valid_r <= accept_s;
      err_r       <= bus.in_valid && !in_range_s;
      alarm_r     <= |alarm_next_s;
      if (accept_s) begin
        out_ch_r           <= bus.in_ch;
        out_data_r         <= res_s;
        out_mask_r         <= mask_s;
        last_good_r[idx_s] <= res_s;
      end else begin
        out_ch_r   <= out_ch_r;
        out_data_r <= out_data_r;
        out_mask_r <= out_mask_r;
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      xz_chan_tracker #(
        .CNT_W    (CNT_W),
        .ALARM_TH (ALARM_TH)
      ) u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .ev         (ev_s[c]),
        .count      (xz_count[c]),
        .state      (ch_state[c]),
        .alarm_next (alarm_next_s[c])
      );
    end
  endgenerate

  assign bus.out_valid   = out_valid_r;
  assign bus.out_ch      = out_ch_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_xz_mask = out_mask_r;
  assign err             = err_r;
  assign alarm           = alarm_r;

endmodule

// File: tb/tb_xz_scrub_monitor.sv
// Directed bench for xz_scrub_monitor.
//   u_zero : defaults (RES_ZERO, 4 channels, CNT_W=8, ALARM_TH=4)
//   u_hold : RES_HOLD, 3 channels (also the out-of-range channel case)
//   u_sat  : RES_ONE, CNT_W=2, ALARM_TH=3 (saturation, clear+event)
//   u_trk  : a lone channel tracker driven with raw event strobes
// A two-state simulator stores x/z stimulus bits as ordinary 0/1 values, so
// no event exists there; the expectations follow whichever kind of
// simulator is running, and u_trk covers counting and the FSM in both.
module tb_xz_scrub_monitor;
  import xz_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic probe;
  logic four_state;

  xz_scrub_monitor_if #(.WIDTH(8), .CHANNELS(4)) bz ();
  logic            clr_z;
  logic [3:0][7:0] cnt_z;
  logic [3:0][1:0] st_z;
  logic            alarm_z;
  logic            err_z;

  xz_scrub_monitor #(.WIDTH(8), .CHANNELS(4), .CNT_W(8), .ALARM_TH(4), .MODE(RES_ZERO)) u_zero (
    .clk(clk), .rst_n(rst_n), .bus(bz), .clr(clr_z),
    .xz_count(cnt_z), .ch_state(st_z), .alarm(alarm_z), .err(err_z)
  );

  xz_scrub_monitor_if #(.WIDTH(8), .CHANNELS(3)) bh ();
  logic            clr_h;
  logic [2:0][7:0] cnt_h;
  logic [2:0][1:0] st_h;
  logic            alarm_h;
  logic            err_h;

  xz_scrub_monitor #(.WIDTH(8), .CHANNELS(3), .CNT_W(8), .ALARM_TH(4), .MODE(RES_HOLD)) u_hold (
    .clk(clk), .rst_n(rst_n), .bus(bh), .clr(clr_h),
    .xz_count(cnt_h), .ch_state(st_h), .alarm(alarm_h), .err(err_h)
  );

  xz_scrub_monitor_if #(.WIDTH(8), .CHANNELS(4)) bs ();
  logic            clr_s;
  logic [3:0][1:0] cnt_s;
  logic [3:0][1:0] st_s;
  logic            alarm_s;
  logic            err_s;

  xz_scrub_monitor #(.WIDTH(8), .CHANNELS(4), .CNT_W(2), .ALARM_TH(3), .MODE(RES_ONE)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bs), .clr(clr_s),
    .xz_count(cnt_s), .ch_state(st_s), .alarm(alarm_s), .err(err_s)
  );

  logic       t_clr;
  logic       t_ev;
  logic [1:0] t_count;
  logic [1:0] t_state;
  logic       t_alarm_next;

  xz_chan_tracker #(.CNT_W(2), .ALARM_TH(3)) u_trk (
    .clk(clk), .rst_n(rst_n), .clr(t_clr), .ev(t_ev),
    .count(t_count), .state(t_state), .alarm_next(t_alarm_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({bz.out_valid, err_z, alarm_z, bh.out_valid, err_h, alarm_h, bs.out_valid, err_s, alarm_s} !== 9'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000000",
               {bz.out_valid, err_z, alarm_z, bh.out_valid, err_h, alarm_h, bs.out_valid, err_s, alarm_s});
    end
    total++;
    if ({bz.out_data, bz.out_xz_mask, bz.out_ch} !== 18'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bz.out_data, bz.out_xz_mask, bz.out_ch});
    end
    total++;
    if ({cnt_z, st_z} !== 40'h0) begin
      bad++;
      $display("FAIL reset_zero_cnt_state: got %h want 0", {cnt_z, st_z});
    end
    total++;
    if ({cnt_h, st_h, cnt_s, st_s, t_count, t_state} !== 50'h0) begin
      bad++;
      $display("FAIL reset_other_cnt_state: got %h want 0", {cnt_h, st_h, cnt_s, st_s, t_count, t_state});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (bz.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got %b want 0", bz.out_valid);
    end
  endtask

  task automatic test_clean_path();
    bz.in_valid = 1'b1;
    bz.in_ch    = 2'd1;
    bz.in_data  = 8'h5A;
    tick();
    bz.in_valid = 1'b0;
    total++;
    if ({bz.out_valid, bz.out_ch, bz.out_data, bz.out_xz_mask} !== {1'b1, 2'd1, 8'h5A, 8'h00}) begin
      bad++;
      $display("FAIL clean_out: got v=%b ch=%0d d=%h m=%h want v=1 ch=1 d=5a m=00",
               bz.out_valid, bz.out_ch, bz.out_data, bz.out_xz_mask);
    end
    total++;
    if ({cnt_z[1], st_z[1]} !== {8'd0, 2'b00}) begin
      bad++;
      $display("FAIL clean_no_event: got cnt=%0d st=%b want cnt=0 st=00", cnt_z[1], st_z[1]);
    end
    tick();
    total++;
    if (bz.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clean_one_cycle: got %b want 0", bz.out_valid);
    end
  endtask

  task automatic test_xz_zero();
    logic [7:0] v;
    logic [7:0] exp_d;
    logic [7:0] exp_m;
    logic [7:0] exp_c;
    logic [1:0] exp_s;
    v = 8'b10xz_1100;
    if (four_state) begin
      exp_d = 8'b1000_1100; exp_m = 8'b0011_0000; exp_c = 8'd1; exp_s = 2'b01;
    end else begin
      exp_d = v; exp_m = 8'h00; exp_c = 8'd0; exp_s = 2'b00;
    end
    bz.in_valid = 1'b1;
    bz.in_ch    = 2'd0;
    bz.in_data  = v;
    tick();
    bz.in_valid = 1'b0;
    total++;
    if ({bz.out_valid, bz.out_data} !== {1'b1, exp_d}) begin
      bad++;
      $display("FAIL zero_data: got v=%b d=%h want v=1 d=%h", bz.out_valid, bz.out_data, exp_d);
    end
    total++;
    if (bz.out_xz_mask !== exp_m) begin
      bad++;
      $display("FAIL zero_mask: got %h want %h", bz.out_xz_mask, exp_m);
    end
    total++;
    if ({cnt_z[0], st_z[0]} !== {exp_c, exp_s}) begin
      bad++;
      $display("FAIL zero_count_state: got cnt=%0d st=%b want cnt=%0d st=%b", cnt_z[0], st_z[0], exp_c, exp_s);
    end
  endtask

  task automatic test_alarm();
    logic [7:0] exp_c;
    logic [1:0] exp_s;
    logic       exp_a;
    clr_z = 1'b1;
    tick();
    clr_z = 1'b0;
    total++;
    if ({cnt_z, st_z} !== 40'h0) begin
      bad++;
      $display("FAIL alarm_clr: got %h want 0", {cnt_z, st_z});
    end
    for (int k = 1; k <= 4; k++) begin
      bz.in_valid = 1'b1;
      bz.in_ch    = 2'd2;
      bz.in_data  = 8'b0000_000x;
      tick();
      bz.in_valid = 1'b0;
      exp_c = four_state ? 8'(k) : 8'd0;
      exp_s = !four_state ? 2'b00 : ((k >= 4) ? 2'b10 : 2'b01);
      exp_a = four_state && (k >= 4);
      total++;
      if ({cnt_z[2], st_z[2], alarm_z} !== {exp_c, exp_s, exp_a}) begin
        bad++;
        $display("FAIL alarm_step%0d: got cnt=%0d st=%b alarm=%b want cnt=%0d st=%b alarm=%b",
                 k, cnt_z[2], st_z[2], alarm_z, exp_c, exp_s, exp_a);
      end
      if (k == 2) begin
        bz.in_valid = 1'b1;
        bz.in_data  = 8'hFF;
        tick();
        bz.in_valid = 1'b0;
        total++;
        if ({cnt_z[2], st_z[2]} !== {exp_c, exp_s}) begin
          bad++;
          $display("FAIL alarm_clean_no_change: got cnt=%0d st=%b want cnt=%0d st=%b",
                   cnt_z[2], st_z[2], exp_c, exp_s);
        end
      end
    end
    total++;
    if ({cnt_z[3], cnt_z[1], cnt_z[0], st_z[3], st_z[1], st_z[0]} !== 30'h0) begin
      bad++;
      $display("FAIL alarm_others: got %h want 0", {cnt_z[3], cnt_z[1], cnt_z[0], st_z[3], st_z[1], st_z[0]});
    end
  endtask

  task automatic test_hold();
    logic [7:0] v;
    v = 8'bxxxx_0000;
    bh.in_valid = 1'b1;
    bh.in_ch    = 2'd1;
    bh.in_data  = 8'hA5;
    tick();
    total++;
    if ({bh.out_valid, bh.out_data} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL hold_first: got v=%b d=%h want v=1 d=a5", bh.out_valid, bh.out_data);
    end
    bh.in_data = v;
    tick();
    bh.in_valid = 1'b0;
    total++;
    if ({bh.out_valid, bh.out_data, bh.out_xz_mask} !== {1'b1, (four_state ? 8'hA0 : v), (four_state ? 8'hF0 : 8'h00)}) begin
      bad++;
      $display("FAIL hold_second: got v=%b d=%h m=%h want v=1 d=%h m=%h", bh.out_valid, bh.out_data,
               bh.out_xz_mask, (four_state ? 8'hA0 : v), (four_state ? 8'hF0 : 8'h00));
    end
    total++;
    if ({cnt_h[1], st_h[1]} !== {(four_state ? 8'd1 : 8'd0), (four_state ? 2'b01 : 2'b00)}) begin
      bad++;
      $display("FAIL hold_count_state: got cnt=%0d st=%b", cnt_h[1], st_h[1]);
    end
  endtask

  task automatic test_hold_clr();
    logic [7:0] v;
    v = 8'bxxxx_xxxx;
    clr_h = 1'b1;
    tick();
    clr_h = 1'b0;
    total++;
    if ({cnt_h[1], st_h[1]} !== {8'd0, 2'b00}) begin
      bad++;
      $display("FAIL hold_clr: got cnt=%0d st=%b want cnt=0 st=00", cnt_h[1], st_h[1]);
    end
    // Last-good must survive the clear: every bit comes back from A0.
    bh.in_valid = 1'b1;
    bh.in_ch    = 2'd1;
    bh.in_data  = v;
    tick();
    bh.in_valid = 1'b0;
    total++;
    if ({bh.out_data, bh.out_xz_mask} !== {(four_state ? 8'hA0 : v), (four_state ? 8'hFF : 8'h00)}) begin
      bad++;
      $display("FAIL hold_lastgood_kept: got d=%h m=%h want d=%h m=%h", bh.out_data, bh.out_xz_mask,
               (four_state ? 8'hA0 : v), (four_state ? 8'hFF : 8'h00));
    end
  endtask

  task automatic test_res_one_sat();
    logic [7:0] v;
    logic [7:0] w;
    logic [1:0] exp_c;
    logic [1:0] exp_s;
    v = 8'b0x0x_0000;
    w = 8'b0000_000x;
    bs.in_valid = 1'b1;
    bs.in_ch    = 2'd0;
    bs.in_data  = v;
    tick();
    total++;
    if ({bs.out_data, bs.out_xz_mask} !== {(four_state ? 8'h50 : v), (four_state ? 8'h50 : 8'h00)}) begin
      bad++;
      $display("FAIL one_resolve: got d=%h m=%h want d=%h m=%h", bs.out_data, bs.out_xz_mask,
               (four_state ? 8'h50 : v), (four_state ? 8'h50 : 8'h00));
    end
    for (int k = 1; k <= 5; k++) begin
      bs.in_ch   = 2'd3;
      bs.in_data = w;
      tick();
      exp_c = four_state ? ((k < 3) ? 2'(k) : 2'd3) : 2'd0;
      exp_s = !four_state ? 2'b00 : ((k >= 3) ? 2'b10 : 2'b01);
      total++;
      if ({cnt_s[3], st_s[3], alarm_s} !== {exp_c, exp_s, (four_state && k >= 3)}) begin
        bad++;
        $display("FAIL sat_step%0d: got cnt=%0d st=%b alarm=%b want cnt=%0d st=%b alarm=%b",
                 k, cnt_s[3], st_s[3], alarm_s, exp_c, exp_s, (four_state && k >= 3));
      end
    end
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    bs.in_valid = 1'b0;
    total++;
    if ({cnt_s[3], st_s[3], alarm_s} !== {(four_state ? 2'd1 : 2'd0), (four_state ? 2'b01 : 2'b00), 1'b0}) begin
      bad++;
      $display("FAIL clr_with_event: got cnt=%0d st=%b alarm=%b", cnt_s[3], st_s[3], alarm_s);
    end
    total++;
    if ({bs.out_valid, bs.out_ch} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL clr_keeps_pipeline: got v=%b ch=%0d want v=1 ch=3", bs.out_valid, bs.out_ch);
    end
    total++;
    if ({cnt_s[2:0], st_s[2:0]} !== 12'h0) begin
      bad++;
      $display("FAIL clr_all_channels: got %h want 0", {cnt_s[2:0], st_s[2:0]});
    end
  endtask

  task automatic test_range_err();
    clr_h = 1'b1;
    tick();
    clr_h = 1'b0;
    bh.in_valid = 1'b1;
    bh.in_ch    = 2'd3;
    bh.in_data  = 8'bxxxx_xxxx;
    tick();
    bh.in_valid = 1'b0;
    total++;
    if ({bh.out_valid, err_h} !== 2'b01) begin
      bad++;
      $display("FAIL range_drop: got v=%b err=%b want v=0 err=1", bh.out_valid, err_h);
    end
    total++;
    if ({cnt_h, st_h} !== 30'h0) begin
      bad++;
      $display("FAIL range_no_state: got %h want 0", {cnt_h, st_h});
    end
    tick();
    total++;
    if (err_h !== 1'b0) begin
      bad++;
      $display("FAIL range_err_pulse: got %b want 0", err_h);
    end
    bh.in_valid = 1'b1;
    bh.in_ch    = 2'd2;
    bh.in_data  = 8'h11;
    tick();
    bh.in_valid = 1'b0;
    total++;
    if ({bh.out_valid, bh.out_ch, bh.out_data, err_h} !== {1'b1, 2'd2, 8'h11, 1'b0}) begin
      bad++;
      $display("FAIL range_last_channel: got v=%b ch=%0d d=%h err=%b want v=1 ch=2 d=11 err=0",
               bh.out_valid, bh.out_ch, bh.out_data, err_h);
    end
  endtask

  task automatic test_tracker();
    logic [1:0] tv_in  [10];
    logic [1:0] tv_cnt [10];
    logic [1:0] tv_st  [10];
    // {clr, ev} per cycle with the count/state expected after that edge.
    tv_in  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
    tv_cnt = '{2'd1,  2'd2,  2'd3,  2'd3,  2'd3,  2'd0,  2'd0,  2'd1,  2'd1,  2'd1};
    tv_st  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 10; i++) begin
      t_clr = tv_in[i][1];
      t_ev  = tv_in[i][0];
      tick();
      t_clr = 1'b0;
      t_ev  = 1'b0;
      #1;
      total++;
      if ({t_count, t_state, t_alarm_next} !== {tv_cnt[i], tv_st[i], (tv_st[i] == 2'b10)}) begin
        bad++;
        $display("FAIL tracker_step%0d: got cnt=%0d st=%b an=%b want cnt=%0d st=%b an=%b", i,
                 t_count, t_state, t_alarm_next, tv_cnt[i], tv_st[i], (tv_st[i] == 2'b10));
      end
    end
  endtask

  task automatic test_reset_mid();
    bz.in_valid = 1'b1;
    bz.in_ch    = 2'd3;
    bz.in_data  = 8'h3C;
    tick();
    total++;
    if ({bz.out_valid, bz.out_data} !== {1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL mid_before: got v=%b d=%h want v=1 d=3c", bz.out_valid, bz.out_data);
    end
    bz.in_ch   = 2'd1;
    bz.in_data = 8'hC3;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bz.out_valid, bz.out_ch, bz.out_data, bz.out_xz_mask, err_z, alarm_z} !== 21'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 0",
               {bz.out_valid, bz.out_ch, bz.out_data, bz.out_xz_mask, err_z, alarm_z});
    end
    total++;
    if ({cnt_z, st_z, t_count, t_state} !== 44'h0) begin
      bad++;
      $display("FAIL mid_reset_state: got %h want 0", {cnt_z, st_z, t_count, t_state});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (bz.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_inflight_dropped: got %b want 0", bz.out_valid);
    end
    rst_n = 1'b1;
    tick();
    bz.in_valid = 1'b0;
    total++;
    if ({bz.out_valid, bz.out_ch, bz.out_data} !== {1'b1, 2'd1, 8'hC3}) begin
      bad++;
      $display("FAIL mid_first_after_release: got v=%b ch=%0d d=%h want v=1 ch=1 d=c3",
               bz.out_valid, bz.out_ch, bz.out_data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    probe = 1'bx;
    four_state = $isunknown(probe);
    rst_n = 1'b0;
    clr_z = 1'b0; clr_h = 1'b0; clr_s = 1'b0;
    t_clr = 1'b0; t_ev  = 1'b0;
    bz.in_valid = 1'b0; bz.in_ch = 2'd0; bz.in_data = 8'h00;
    bh.in_valid = 1'b0; bh.in_ch = 2'd0; bh.in_data = 8'h00;
    bs.in_valid = 1'b0; bs.in_ch = 2'd0; bs.in_data = 8'h00;

    test_reset();
    test_clean_path();
    test_xz_zero();
    test_alarm();
    test_hold();
    test_hold_clr();
    test_res_one_sat();
    test_range_err();
    test_tracker();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xz_scrub_monitor.md
XZ_SCRUB_MONITOR -- requirements
Module: xz_scrub_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per sample.
REQ-002 The block SHALL have parameter CHANNELS, default 4: number of independent channels.
REQ-003 The block SHALL have parameter CNT_W, default 8: per-channel X/Z event counter width.
REQ-004 The block SHALL have parameter ALARM_TH, default 4: event count that triggers ALARM (1..2^CNT_W-1).
REQ-005 The block SHALL have parameter MODE, default RES_ZERO: X/Z resolve policy, one of RES_ZERO, RES_ONE, RES_HOLD.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port in_valid, input, 1: in_ch/in_data are sampled this cycle.
REQ-009 Port in_ch, input, $clog2(CHANNELS) (min 1): target channel.
REQ-010 Port in_data, input, WIDTH, 4-state logic: raw sample, may contain 0/1/x/z bits.
REQ-011 Port clr, input, 1: clears all counters, sticky flags and channel states.
REQ-012 Port out_valid, output, 1: scrubbed sample is presented.
REQ-013 Port out_ch, output, $clog2(CHANNELS): channel of the presented sample.
REQ-014 Port out_data, output, WIDTH: scrubbed sample, only 0/1 bits.
REQ-015 Port out_xz_mask, output, WIDTH: 1 where the input bit was x or z.
REQ-016 Port xz_count, output, CHANNELS x CNT_W: per-channel saturating event counts.
REQ-017 Port ch_state, output, CHANNELS x 2: per-channel state encoding.
REQ-018 Port alarm, output, 1: OR of all channels in ALARM.
REQ-019 Port err, output, 1: one-cycle pulse on out-of-range in_ch.

Function
REQ-020 Latency SHALL be exactly 1 cycle: an accepted sample at edge N appears on out_valid/out_ch/out_data/out_xz_mask after edge N, held 1 cycle only.
REQ-021 X/Z detection SHALL be per bit using 4-state case-equality; an "event" is an accepted sample with any mask bit set.
REQ-022 Resolve: RES_ZERO forces flagged bits to 0; RES_ONE forces them to 1; RES_HOLD uses that bit of the channel's last-good register.
REQ-023 Per channel, the last-good register SHALL update with every accepted sample's resolved value.
REQ-024 Each event SHALL increment that channel's xz_count by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-025 Channel FSM states: CLEAN(00), DIRTY(01), ALARM(10); 11 unused, recovers to CLEAN.
REQ-026 CLEAN->DIRTY on first event; DIRTY->ALARM when post-increment count >= ALARM_TH; ALARM leaves only via clr or reset.
REQ-027 Clean (no-X/Z) samples SHALL not change count or state.
REQ-028 in_ch >= CHANNELS: sample dropped (out_valid stays 0), err pulses next cycle, no state change.
REQ-029 clr SHALL zero all counts and return all channels to CLEAN; last-good registers are retained.
REQ-030 clr and an event in the same cycle: clear applied first, then the event, giving count 1, state DIRTY (or ALARM if ALARM_TH=1).
REQ-031 clr SHALL not affect the output data pipeline stage.

Reset
REQ-032 rst_n low SHALL immediately clear out_valid, out_ch, out_data, out_xz_mask, err, all counts, last-good registers, alarm, and set all states to CLEAN.
REQ-033 An in-flight sample at reset assertion SHALL be discarded; the first accepted sample after release follows REQ-020.

Structure
REQ-034 Package xz_pkg SHALL hold the resolve-mode enum (RES_ZERO/RES_ONE/RES_HOLD) and the channel-state enum.
REQ-035 Per-channel counter+FSM SHALL be sub-module xz_chan_tracker, instantiated CHANNELS times via generate.

Verification
REQ-036 MODE=RES_ZERO, ch0 in_data=8'b10xz_1100 -> next cycle out_data=8'b1000_1100, out_xz_mask=8'b0011_0000, count[0]=1, DIRTY.
REQ-037 RES_HOLD, ch1 sends 8'hA5 then 8'bxxxx_0000 -> second out_data=8'hA0.
REQ-038 Four events on ch2, ALARM_TH=4 -> ch_state[2]=ALARM and alarm=1 after the 4th; ch0/ch1/ch3 unaffected.
REQ-039 CNT_W=2, five events on ch3 -> count[3] stays 3; clr with an event same cycle -> count 1, DIRTY.
REQ-040 CHANNELS=3, in_ch=3 -> no out_valid, err 1-cycle pulse; rst_n low mid-stream -> all outputs 0 immediately.
